// File: rtl/shift_exec_stage.sv
//============================================================================
// Module   : shift_exec_stage
// Purpose  : Execute-stage sequencer for shift/rotate instructions. Accepts
//            one op from decode, drives an external combinational barrel
//            shifter (one pass for SLL/SRL/SRA, two passes for ROL), and
//            holds the result and Z/N/C flags until writeback consumes it.
// Macro    : SHIFT_EXEC_FLUSH_EN - adds a 'flush' input that aborts any
//            in-flight op and returns the stage to IDLE.
// Ports    : clk, rst              clock, synchronous active-high reset
//            in_valid/in_ready     decode handshake
//            in_op/in_data/in_amt  operation, operand, shift amount
//            sh_in/sh_amt/sh_sign/sh_cont  drive to the barrel shifter
//            sh_out                result returned by the barrel shifter
//            out_valid/out_ready   writeback handshake
//            out_data/out_z/out_n/out_c  result and flags
//            flush                 (SHIFT_EXEC_FLUSH_EN only) abort
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module shift_exec_stage #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
`ifdef SHIFT_EXEC_FLUSH_EN
    input  logic         flush,
`endif
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [1:0]   in_op,
    input  logic [W-1:0] in_data,
    input  logic [W-1:0] in_amt,
    output logic [W-1:0] sh_in,
    output logic [W-1:0] sh_amt,
    output logic         sh_sign,
    output logic         sh_cont,
    input  logic [W-1:0] sh_out,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         out_z,
    output logic         out_n,
    output logic         out_c
);

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_ROL = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PASS1 = 2'd1,
        S_PASS2 = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t         state_q;
    logic [1:0]     op_q;
    logic [W-1:0]   data_q;
    logic [W-1:0]   amt_q;
    logic [W-1:0]   tmp_q;
    logic [W-1:0]   sh_in_q;
    logic [W-1:0]   sh_amt_q;
    logic           sh_sign_q;
    logic           sh_cont_q;
    logic           out_valid_q;
    logic [W-1:0]   out_data_q;
    logic           out_z_q;
    logic           out_n_q;
    logic           out_c_q;

    logic           flush_w;
    logic [4:0]     n_eff_d;
    logic [3:0]     sll_idx_d;
    logic [3:0]     srl_idx_d;
    logic           shift_c_d;
    logic [W-1:0]   rol_res_d;
    logic           rol_c_d;
    logic [4:0]     rol_back_d;

`ifdef SHIFT_EXEC_FLUSH_EN
    assign flush_w = flush;
`else
    assign flush_w = 1'b0;
`endif

    // Carry is derived from the latched operand rather than from the
    // shifter, since the shifter reports no shifted-out bit.
    always_comb begin
        // Effective amount mirrors the shifter's saturation to 31.
        n_eff_d   = (|amt_q[W-1:5]) ? 5'd31 : amt_q[4:0];
        // 16-n and n-1 taken modulo 16; valid for 1 <= n <= 16.
        sll_idx_d = 4'd0 - n_eff_d[3:0];
        srl_idx_d = n_eff_d[3:0] - 4'd1;
        shift_c_d = 1'b0;
        if (n_eff_d != 5'd0) begin
            case (op_q)
                OP_SLL: shift_c_d = (n_eff_d <= 5'd16) ? data_q[sll_idx_d] : 1'b0;
                OP_SRL: shift_c_d = (n_eff_d <= 5'd16) ? data_q[srl_idx_d] : 1'b0;
                OP_SRA: shift_c_d = (n_eff_d <= 5'd16) ? data_q[srl_idx_d] : data_q[W-1];
                default: shift_c_d = 1'b0;
            endcase
        end
        // Second ROL pass: right shift by 16-r; r=0 gives 16, i.e. zero.
        rol_back_d = 5'd16 - {1'b0, amt_q[3:0]};
        rol_res_d  = tmp_q | sh_out;
        rol_c_d    = (amt_q[3:0] != 4'd0) & rol_res_d[0];
    end

    // The sh_* drive is registered and loaded one edge ahead, so it is
    // already stable throughout PASS1/PASS2 and holds elsewhere.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            op_q        <= 2'b00;
            data_q      <= '0;
            amt_q       <= '0;
            tmp_q       <= '0;
            sh_in_q     <= '0;
            sh_amt_q    <= '0;
            sh_sign_q   <= 1'b0;
            sh_cont_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_z_q     <= 1'b0;
            out_n_q     <= 1'b0;
            out_c_q     <= 1'b0;
        end else if (flush_w) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        op_q      <= in_op;
                        data_q    <= in_data;
                        amt_q     <= in_amt;
                        sh_in_q   <= in_data;
                        sh_amt_q  <= (in_op == OP_ROL) ? {{(W-4){1'b0}}, in_amt[3:0]} : in_amt;
                        sh_cont_q <= (in_op == OP_SRL) || (in_op == OP_SRA);
                        sh_sign_q <= (in_op == OP_SRA);
                        state_q   <= S_PASS1;
                    end
                end
                S_PASS1: begin
                    if (op_q == OP_ROL) begin
                        tmp_q     <= sh_out;
                        sh_amt_q  <= {{(W-5){1'b0}}, rol_back_d};
                        sh_cont_q <= 1'b1;
                        sh_sign_q <= 1'b0;
                        state_q   <= S_PASS2;
                    end else begin
                        out_data_q  <= sh_out;
                        out_z_q     <= (sh_out == '0);
                        out_n_q     <= sh_out[W-1];
                        out_c_q     <= shift_c_d;
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end
                end
                S_PASS2: begin
                    out_data_q  <= rol_res_d;
                    out_z_q     <= (rol_res_d == '0);
                    out_n_q     <= rol_res_d[W-1];
                    out_c_q     <= rol_c_d;
                    out_valid_q <= 1'b1;
                    state_q     <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign sh_in     = sh_in_q;
    assign sh_amt    = sh_amt_q;
    assign sh_sign   = sh_sign_q;
    assign sh_cont   = sh_cont_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_z     = out_z_q;
    assign out_n     = out_n_q;
    assign out_c     = out_c_q;

endmodule

`default_nettype wire
